// File: rtl/sync_fifo_param_if.sv
// Bus bundle for sync_fifo_param: write/read handshakes, flush, data and status.
// The master modport belongs to the producer/consumer side; slave is the FIFO.
interface sync_fifo_param_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  ws;
   logic                  we;
   logic                  rs;
   logic                  re;
   logic                  clear;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output data_in, ws, we, rs, re, clear,
      input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  data_in, ws, we, rs, re, clear,
      output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow, synchronous flush, registered or FWFT read data.
module sync_fifo_param #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
   parameter int unsigned AE_LEVEL   = 2,
   parameter bit          FWFT       = 1'b0
) (
   input logic               clk,
   input logic               reset,
   sync_fifo_param_if.slave  bus
);
   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   AF_C     = AF_LEVEL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   AE_C     = AE_LEVEL[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  wr_req, rd_req, wr_acc, rd_acc;
   logic                  full, empty;

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= AF_C);
   assign bus.almost_empty = (count_q <= AE_C);
   assign bus.count        = count_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

   // Read data: head of the queue in FWFT mode, last popped word otherwise
   always_comb begin
      bus.data_out = (FWFT != 1'b0) ? mem_q[rd_ptr_q] : dout_q;
   end

   // Accept logic and next-state for pointers, occupancy, read data and error flags
   always_comb begin
      wr_req   = bus.ws & bus.we;
      rd_req   = bus.rs & bus.re;
      // flush wins: same-cycle requests are dropped and raise no error
      rd_acc   = rd_req & ~empty & ~bus.clear;
      wr_acc   = wr_req & (~full | rd_acc) & ~bus.clear;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      dout_d   = dout_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      if (bus.clear) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            dout_d   = mem_q[rd_ptr_q];
         end
         if (wr_acc && !rd_acc) count_d = count_q + CNT_ONE;
         if (rd_acc && !wr_acc) count_d = count_q - CNT_ONE;
         if (wr_req && !wr_acc) ovf_d = 1'b1;
         if (rd_req && !rd_acc) unf_d = 1'b1;
      end
   end

   // Control state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage array write port, not reset
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
   end
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered (dut0) and FWFT (dut1) instances share
// identical stimulus; a queue-based reference model feeds a scoreboard monitor.
module tb_sync_fifo_param;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 4;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AF = 14;
   localparam int unsigned AE = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
   sync_fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

   sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0))
      dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
   sync_fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1))
      dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

   typedef struct {
      int          cnt;
      bit          ovf;
      bit          unf;
      logic [7:0]  dout0;
      bit          hv;
      logic [7:0]  head;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mq[$];
   bit         m_ovf, m_unf;
   logic [7:0] m_dout;
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_inputs(input logic [1:0] wsel, input logic [1:0] rsel, input logic [7:0] d, input bit clr);
      {if0.ws, if0.we} = wsel;  {if1.ws, if1.we} = wsel;
      {if0.rs, if0.re} = rsel;  {if1.rs, if1.re} = rsel;
      if0.data_in = d;          if1.data_in = d;
      if0.clear = clr;          if1.clear = clr;
   endtask

   // One cycle of stimulus; the reference model decides the outcome from the rules
   task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit clr);
      logic [1:0] wsel, rsel;
      bit rd_ok, wr_ok;
      exp_t e;
      @(negedge clk);
      wsel = w ? 2'b11 : 2'($urandom_range(0, 2));
      rsel = r ? 2'b11 : 2'($urandom_range(0, 2));
      set_inputs(wsel, rsel, d, clr);
      rd_ok = r && (mq.size() > 0) && !clr;
      wr_ok = w && ((mq.size() < DEPTH) || rd_ok) && !clr;
      if (clr) begin
         mq.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (w && !wr_ok) m_ovf = 1'b1;
         if (r && !rd_ok) m_unf = 1'b1;
         if (rd_ok) m_dout = mq.pop_front();
         if (wr_ok) mq.push_back(d);
      end
      e.cnt   = mq.size();
      e.ovf   = m_ovf;
      e.unf   = m_unf;
      e.dout0 = m_dout;
      e.hv    = (mq.size() > 0);
      e.head  = (mq.size() > 0) ? mq[0] : 8'h00;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_dout = 8'h00;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".count"}, 32'(if0.count), 0);
      chk({tag, ".empty"}, 32'(if0.empty), 1);
      chk({tag, ".full"},  32'(if0.full), 0);
      chk({tag, ".ae"},    32'(if0.almost_empty), 1);
      chk({tag, ".af"},    32'(if0.almost_full), 0);
      chk({tag, ".ovf"},   32'(if0.overflow), 0);
      chk({tag, ".unf"},   32'(if0.underflow), 0);
      chk({tag, ".dout"},  32'(if0.data_out), 0);
      chk({tag, ".count1"}, 32'(if1.count), 0);
      chk({tag, ".empty1"}, 32'(if1.empty), 1);
   endtask

   // Monitor: after every edge, pop the expectation for it and compare both DUTs
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset && sb.size() > 0) begin
            e = sb.pop_front();
            chk("count0", 32'(if0.count), 32'(e.cnt));
            chk("full0",  32'(if0.full), 32'(e.cnt == DEPTH));
            chk("empty0", 32'(if0.empty), 32'(e.cnt == 0));
            chk("af0",    32'(if0.almost_full), 32'(e.cnt >= AF));
            chk("ae0",    32'(if0.almost_empty), 32'(e.cnt <= AE));
            chk("ovf0",   32'(if0.overflow), 32'(e.ovf));
            chk("unf0",   32'(if0.underflow), 32'(e.unf));
            chk("dout0",  32'(if0.data_out), 32'(e.dout0));
            chk("count1", 32'(if1.count), 32'(e.cnt));
            chk("empty1", 32'(if1.empty), 32'(e.cnt == 0));
            chk("ovf1",   32'(if1.overflow), 32'(e.ovf));
            chk("unf1",   32'(if1.underflow), 32'(e.unf));
            if (e.hv) chk("head1", 32'(if1.data_out), 32'(e.head));
         end
      end
   end

   initial begin
      int written;
      reset = 1'b0;
      set_inputs(2'b00, 2'b00, 8'h00, 1'b0);
      model_reset();
      #1;
      chk_reset_state("rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;

      // fill to full, then drain in order
      for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // full: rejected write, then write+read accepted together
      for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i + 32), 1'b0, 1'b0);
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      drive(1'b1, 8'hBB, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);

      // empty: read rejected while same-cycle write lands
      drive(1'b1, 8'h55, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b1);

      // FWFT head visibility
      drive(1'b1, 8'h3C, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      // interleaved traffic across the pointer wrap, occupancy 3..6
      written = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
         written++;
      end
      for (int k = 0; k < 200 && written < 20; k++) begin
         if (mq.size() <= 3) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
            written++;
         end else if (mq.size() >= 6) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
         end else begin
            bit w, r;
            w = 1'($urandom_range(0, 1));
            r = !w || (1'($urandom_range(0, 1)));
            drive(w, 8'($urandom_range(0, 255)), r, 1'b0);
            if (w) written++;
         end
      end
      while (mq.size() > 0) drive(1'b0, 8'h00, 1'b1, 1'b0);

      // random traffic with occasional flush
      for (int k = 0; k < 400; k++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), $urandom_range(0, 40) == 0);
      end

      // flush with count=5 and overflow set, plus a dropped write
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'h77, 1'b0, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      drive(1'b1, 8'h91, 1'b0, 1'b0);
      drive(1'b1, 8'h92, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // asynchronous reset away from any clock edge
      @(posedge clk);
      #3;
      set_inputs(2'b00, 2'b00, 8'h00, 1'b0);
      reset = 1'b0;
      #1;
      chk_reset_state("midrst");
      model_reset();
      sb.delete();
      @(posedge clk);
      #1;
      chk_reset_state("rsthold");
      @(negedge clk);
      reset = 1'b1;

      drive(1'b1, 8'hC3, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 30; k++) begin
         drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);

      for (int k = 0; k < 4 && sb.size() > 0; k++) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO and the successor to the team's basic FIFO. It adds configurable width and depth, true simultaneous read/write, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable read mode (registered or first-word-fall-through). It is used as the general buffering primitive between producer and consumer blocks in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each stored word.
ADDR_WIDTH, 8, pointer width; DEPTH = 1<<ADDR_WIDTH words.
AF_LEVEL, (1<<ADDR_WIDTH)-2, almost_full asserts when count >= AF_LEVEL.
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
data_in  input  DATA_WIDTH  write data.
ws  input  1  write select.
we  input  1  write enable; write request wr_req = ws & we.
rs  input  1  read select.
re  input  1  read enable; read request rd_req = rs & re.
clear  input  1  synchronous flush, active-high.
data_out  output  DATA_WIDTH  read data.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_LEVEL.
almost_empty  output  1  count <= AE_LEVEL.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a write was rejected.
underflow  output  1  sticky: a read was rejected.

Behaviour:
- Reset (reset=0, asynchronous): rd_ptr=0, wr_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Therefore empty=1, full=0, almost_empty=1, and almost_full=(AF_LEVEL==0). Storage array is not reset.
- rd_acc = rd_req & !empty. A read on an empty FIFO is rejected even if a write is accepted in the same cycle.
- wr_acc = wr_req & (!full | rd_acc). A write while full is accepted only when a read is accepted in the same cycle.
- wr_acc: mem[wr_ptr] <= data_in; wr_ptr += 1, wrapping modulo DEPTH.
- rd_acc: rd_ptr += 1, wrapping modulo DEPTH.
- count: +1 if wr_acc & !rd_acc; -1 if rd_acc & !wr_acc; otherwise unchanged. It never exceeds DEPTH and never goes below 0.
- full, empty, almost_full and almost_empty are combinational from the registered count, so they reflect an accepted operation on the cycle after the edge.
- FWFT=0: on rd_acc, data_out <= mem[rd_ptr] at the same edge; data_out then holds until the next rd_acc. Read data appears 1 cycle after the request.
- FWFT=1: data_out = mem[rd_ptr] combinationally, so the head word is visible while empty=0. rd_acc pops it, and the next word appears after the edge. data_out is undefined while empty=1 and must not be checked.
- overflow is set on wr_req & !wr_acc. underflow is set on rd_req & !rd_acc. Both stay set until clear=1 or reset.
- clear=1: at the edge, rd_ptr, wr_ptr, count, overflow and underflow go to 0. A same-cycle wr_req or rd_req is dropped and does not set an error flag. data_out holds its value when FWFT=0.
- Pointer wrap: after DEPTH writes and DEPTH reads, both pointers return to 0 and FIFO order is preserved across the wrap.
- Reset asserted mid-operation returns every output to its reset value immediately, regardless of the clock. The first operation is accepted on the first rising edge after reset deasserts.

Test Plan:
1. ADDR_WIDTH=4, FWFT=0: after reset, write 0x01..0x10 (16 words) -> full=1, count=16, almost_full=1 from count=14. Read 16 times -> data_out returns 0x01..0x10 in order, each 1 cycle after its read, and empty=1 at the end.
2. With the FIFO full, a write of 0xAA and no read -> overflow=1, count stays 16, and 0xAA never appears. With the FIFO full, a write of 0xBB plus a read in the same cycle -> both accepted, count=16, and 0xBB is the last word read out.
3. With the FIFO empty, a read plus a write of 0x55 in the same cycle -> read rejected, underflow=1, count=1. The next read returns 0x55.
4. FWFT=1: write 0x3C -> data_out=0x3C while empty=0 with no read issued. Read -> empty=1 next cycle.
5. Write 20 words and read 20 words interleaved, keeping count between 3 and 6 -> pointers wrap, order is preserved, and no error flags are set.
6. With count=5 and overflow=1: assert clear alongside a write -> next cycle count=0, overflow=0, empty=1. Then pull reset low mid-cycle -> data_out=0 and count=0 immediately.
